// File: rtl/mic_capture_sequencer.sv
// I2S microphone capture sequencer: holds the receiver in reset, waits out mic settling, then streams
// {left,right} frames into the sample buffer. Define PEAK_DETECT_EN to add per-channel peak outputs.
module mic_capture_sequencer #(
    parameter int ADDR_WIDTH      = 10,
    parameter int SETTLE_FRAMES   = 2048,
    parameter int RX_RESET_CYCLES = 4,
    parameter int WATCHDOG_CYCLES = 4096
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  start_in,
    input  logic                  stop_in,
    input  logic [ADDR_WIDTH:0]   capture_len_in,
    output logic                  rx_reset_out,
    input  logic [15:0]           rx_left_in,
    input  logic [15:0]           rx_right_in,
    input  logic                  rx_new_sample_in,
    output logic                  buf_we_out,
    output logic [ADDR_WIDTH-1:0] buf_addr_out,
    output logic [31:0]           buf_data_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  error_out,
    output logic [2:0]            state_out,
    output logic [ADDR_WIDTH:0]   frames_written_out
`ifdef PEAK_DETECT_EN
    ,
    output logic [15:0]           peak_left_out,
    output logic [15:0]           peak_right_out
`endif
);

    // state    | meaning
    // IDLE     | receiver held in reset, waiting for start
    // RESET_RX | receiver reset pulse of RX_RESET_CYCLES clocks
    // SETTLE   | receiver running, frames discarded while mics power up
    // CAPTURE  | every new frame written to the buffer
    // DONE     | fixed-length capture finished, done pulse
    // FAULT    | no frames within the watchdog window; receiver held in reset
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RESET_RX = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_CAPTURE  = 3'd3,
        ST_DONE     = 3'd4,
        ST_FAULT    = 3'd5
    } state_t;

    localparam int RST_W    = (RX_RESET_CYCLES > 1) ? $clog2(RX_RESET_CYCLES) : 1;
    localparam int SETTLE_W = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;
    localparam int WD_W     = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;

    localparam logic [RST_W-1:0]    RST_LOAD    = RST_W'(RX_RESET_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_FRAMES - 1);
    localparam logic [WD_W-1:0]     WD_LOAD     = WD_W'(WATCHDOG_CYCLES - 1);

    state_t                  state;
    logic [ADDR_WIDTH:0]     len_left;
    logic                    continuous;
    logic [ADDR_WIDTH-1:0]   addr_cnt;
    logic [RST_W-1:0]        rst_cnt;
    logic [SETTLE_W-1:0]     settle_cnt;
    logic [WD_W-1:0]         wd_cnt;
    logic                    accept_start;

    assign state_out    = state;
    assign accept_start = start_in && !stop_in && (state == ST_IDLE || state == ST_FAULT);

`ifdef PEAK_DETECT_EN
    // Two's-complement magnitude; -32768 has no positive twin so it clips to 32767.
    function automatic logic [15:0] abs_sat(input logic [15:0] s);
        if (s == 16'h8000)
            return 16'h7fff;
        else if (s[15])
            return ~s + 16'd1;
        else
            return s;
    endfunction

    logic [15:0] mag_left;
    logic [15:0] mag_right;

    assign mag_left  = abs_sat(rx_left_in);
    assign mag_right = abs_sat(rx_right_in);
`endif

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state              <= ST_IDLE;
            rx_reset_out       <= 1'b1;
            buf_we_out         <= 1'b0;
            buf_addr_out       <= '0;
            buf_data_out       <= '0;
            busy_out           <= 1'b0;
            done_out           <= 1'b0;
            error_out          <= 1'b0;
            frames_written_out <= '0;
            len_left           <= '0;
            continuous         <= 1'b0;
            addr_cnt           <= '0;
            rst_cnt            <= '0;
            settle_cnt         <= '0;
            wd_cnt             <= '0;
`ifdef PEAK_DETECT_EN
            peak_left_out      <= '0;
            peak_right_out     <= '0;
`endif
        end else begin
            buf_we_out <= 1'b0;
            done_out   <= 1'b0;

            if (accept_start) begin
                state              <= ST_RESET_RX;
                rx_reset_out       <= 1'b1;
                busy_out           <= 1'b1;
                error_out          <= 1'b0;
                len_left           <= capture_len_in;
                continuous         <= (capture_len_in == '0);
                addr_cnt           <= '0;
                buf_addr_out       <= '0;
                frames_written_out <= '0;
                rst_cnt            <= RST_LOAD;
`ifdef PEAK_DETECT_EN
                peak_left_out      <= '0;
                peak_right_out     <= '0;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        rx_reset_out <= 1'b1;
                    end

                    ST_FAULT: begin
                        if (stop_in) begin
                            state    <= ST_IDLE;
                            busy_out <= 1'b0;
                        end
                    end

                    ST_RESET_RX: begin
                        if (stop_in) begin
                            state        <= ST_IDLE;
                            busy_out     <= 1'b0;
                            rx_reset_out <= 1'b1;
                        end else if (rst_cnt == '0) begin
                            state        <= ST_SETTLE;
                            rx_reset_out <= 1'b0;
                            settle_cnt   <= SETTLE_LOAD;
                            wd_cnt       <= WD_LOAD;
                        end else begin
                            rst_cnt <= rst_cnt - 1'b1;
                        end
                    end

                    ST_SETTLE: begin
                        if (stop_in) begin
                            state        <= ST_IDLE;
                            busy_out     <= 1'b0;
                            rx_reset_out <= 1'b1;
                        end else if (rx_new_sample_in) begin
                            wd_cnt <= WD_LOAD;
                            if (settle_cnt == '0)
                                state <= ST_CAPTURE;
                            else
                                settle_cnt <= settle_cnt - 1'b1;
                        end else if (wd_cnt == '0) begin
                            state        <= ST_FAULT;
                            error_out    <= 1'b1;
                            busy_out     <= 1'b0;
                            rx_reset_out <= 1'b1;
                        end else begin
                            wd_cnt <= wd_cnt - 1'b1;
                        end
                    end

                    ST_CAPTURE: begin
                        if (stop_in) begin
                            state        <= ST_IDLE;
                            busy_out     <= 1'b0;
                            rx_reset_out <= 1'b1;
                        end else if (rx_new_sample_in) begin
                            wd_cnt       <= WD_LOAD;
                            buf_we_out   <= 1'b1;
                            buf_addr_out <= addr_cnt;
                            buf_data_out <= {rx_left_in, rx_right_in};
                            addr_cnt     <= addr_cnt + 1'b1;
                            if (frames_written_out != '1)
                                frames_written_out <= frames_written_out + 1'b1;
`ifdef PEAK_DETECT_EN
                            if (mag_left > peak_left_out)
                                peak_left_out <= mag_left;
                            if (mag_right > peak_right_out)
                                peak_right_out <= mag_right;
`endif
                            if (!continuous) begin
                                len_left <= len_left - 1'b1;
                                if (len_left == (ADDR_WIDTH + 1)'(1)) begin
                                    state    <= ST_DONE;
                                    done_out <= 1'b1;
                                end
                            end
                        end else if (wd_cnt == '0) begin
                            state        <= ST_FAULT;
                            error_out    <= 1'b1;
                            busy_out     <= 1'b0;
                            rx_reset_out <= 1'b1;
                        end else begin
                            wd_cnt <= wd_cnt - 1'b1;
                        end
                    end

                    ST_DONE: begin
                        state        <= ST_IDLE;
                        busy_out     <= 1'b0;
                        rx_reset_out <= 1'b1;
                    end

                    default: begin
                        state        <= ST_IDLE;
                        busy_out     <= 1'b0;
                        rx_reset_out <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mic_capture_sequencer.sv
// Bench for mic_capture_sequencer: directed scenarios plus random traffic, checked every cycle
// against a frame-counting reference model.
module tb_mic_capture_sequencer;

    localparam int AW     = 3;
    localparam int DEPTH  = 1 << AW;
    localparam int SF     = 8;
    localparam int RRC    = 4;
    localparam int WD     = 100;
    localparam int FW_MAX = (1 << (AW + 1)) - 1;

    logic          clock_in = 1'b0;
    logic          reset_in = 1'b1;
    logic          start_in = 1'b0;
    logic          stop_in = 1'b0;
    logic          rx_new_sample_in = 1'b0;
    logic [AW:0]   capture_len_in = '0;
    logic [15:0]   rx_left_in = '0;
    logic [15:0]   rx_right_in = '0;
    logic          rx_reset_out, buf_we_out, busy_out, done_out, error_out;
    logic [AW-1:0] buf_addr_out;
    logic [31:0]   buf_data_out;
    logic [2:0]    state_out;
    logic [AW:0]   frames_written_out;
`ifdef PEAK_DETECT_EN
    logic [15:0]   peak_left_out, peak_right_out;
`endif

    always #5 clock_in = ~clock_in;

    mic_capture_sequencer #(
        .ADDR_WIDTH(AW), .SETTLE_FRAMES(SF), .RX_RESET_CYCLES(RRC), .WATCHDOG_CYCLES(WD)
    ) dut (
        .clock_in(clock_in), .reset_in(reset_in), .start_in(start_in), .stop_in(stop_in),
        .capture_len_in(capture_len_in), .rx_reset_out(rx_reset_out),
        .rx_left_in(rx_left_in), .rx_right_in(rx_right_in), .rx_new_sample_in(rx_new_sample_in),
        .buf_we_out(buf_we_out), .buf_addr_out(buf_addr_out), .buf_data_out(buf_data_out),
        .busy_out(busy_out), .done_out(done_out), .error_out(error_out), .state_out(state_out),
        .frames_written_out(frames_written_out)
`ifdef PEAK_DETECT_EN
        , .peak_left_out(peak_left_out), .peak_right_out(peak_right_out)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic        s_start = 0, s_stop = 0, s_pulse = 0, s_rst = 0;
    logic [15:0] s_left = '0, s_right = '0;
    logic [AW:0] s_len = '0;

    // Reference model: phase number, cycles/pulses seen in the phase, total frames captured.
    int          m_phase = 0, m_hold = 0, m_seen = 0, m_quiet = 0, m_len = 0, m_total = 0;
    bit          m_err = 0, m_we = 0;
    int          m_addr = 0;
    logic [31:0] m_data = '0;
    int          m_pk_l = 0, m_pk_r = 0;

    int wr_log[$];
    int done_cnt = 0, prev_state = 0, settle_at = -1, fault_at = -1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int mag(input logic [15:0] v);
        int x;
        x = int'($signed(v));
        if (x < 0) x = -x;
        if (x > 32767) x = 32767;
        return x;
    endfunction

    task automatic model_begin();
        m_phase = 1; m_hold = 0; m_len = int'(s_len); m_total = 0; m_err = 0;
        m_pk_l = 0; m_pk_r = 0;
    endtask

    task automatic model_step();
        m_we = 0;
        if (s_rst) begin
            m_phase = 0; m_total = 0; m_err = 0; m_pk_l = 0; m_pk_r = 0;
            return;
        end
        case (m_phase)
            0: if (s_start && !s_stop) model_begin();
            5: if (s_stop) m_phase = 0; else if (s_start) model_begin();
            1: begin
                if (s_stop) m_phase = 0;
                else begin
                    m_hold++;
                    if (m_hold == RRC) begin m_phase = 2; m_quiet = 0; m_seen = 0; end
                end
            end
            2, 3: begin
                if (s_stop) m_phase = 0;
                else if (s_pulse) begin
                    m_quiet = 0;
                    if (m_phase == 2) begin
                        m_seen++;
                        if (m_seen == SF) m_phase = 3;
                    end else begin
                        m_we = 1;
                        m_addr = m_total % DEPTH;
                        m_data = {s_left, s_right};
                        m_total++;
                        if (mag(s_left) > m_pk_l) m_pk_l = mag(s_left);
                        if (mag(s_right) > m_pk_r) m_pk_r = mag(s_right);
                        if (m_len != 0 && m_total == m_len) m_phase = 4;
                    end
                end else begin
                    m_quiet++;
                    if (m_quiet == WD) begin m_phase = 5; m_err = 1; end
                end
            end
            4: m_phase = 0;
            default: m_phase = 0;
        endcase
    endtask

    task automatic compare_outputs();
        chk("state", int'(state_out), m_phase);
        chk("rx_reset", int'(rx_reset_out), int'(m_phase == 0 || m_phase == 1 || m_phase == 5));
        chk("busy", int'(busy_out), int'(!(m_phase == 0 || m_phase == 5)));
        chk("done", int'(done_out), int'(m_phase == 4));
        chk("error", int'(error_out), int'(m_err));
        chk("frames", int'(frames_written_out), (m_total > FW_MAX) ? FW_MAX : m_total);
        chk("we", int'(buf_we_out), int'(m_we));
        if (m_we) begin
            chk("addr", int'(buf_addr_out), m_addr);
            chk("data", int'(buf_data_out), int'(m_data));
        end
`ifdef PEAK_DETECT_EN
        chk("peak_left", int'(peak_left_out), m_pk_l);
        chk("peak_right", int'(peak_right_out), m_pk_r);
`endif
    endtask

    task automatic tick();
        reset_in = s_rst; start_in = s_start; stop_in = s_stop;
        rx_new_sample_in = s_pulse; rx_left_in = s_left; rx_right_in = s_right;
        capture_len_in = s_len;
        model_step();
        @(negedge clock_in);
        cyc++;
        compare_outputs();
        if (buf_we_out) wr_log.push_back(int'(buf_addr_out));
        if (done_out) done_cnt++;
        if (state_out == 3'd2 && prev_state != 2) settle_at = cyc;
        if (state_out == 3'd5 && prev_state != 5) fault_at = cyc;
        prev_state = int'(state_out);
        s_start = 0; s_stop = 0; s_pulse = 0; s_rst = 0;
    endtask

    task automatic pulse_gap(input int g);
        repeat (g - 1) tick();
        s_pulse = 1; s_left = 16'($urandom); s_right = 16'($urandom);
        tick();
    endtask

    task automatic run_to_capture(input int len);
        s_len = (AW + 1)'(len); s_start = 1;
        tick();
        repeat (SF) pulse_gap(6);
    endtask

    initial begin
        int gap;
        #1;
        s_rst = 1; tick();
        s_rst = 1; tick();
        chk("reset_state", int'(state_out), 0);
        chk("reset_rx_reset", int'(rx_reset_out), 1);
        chk("reset_frames", int'(frames_written_out), 0);
        repeat (3) tick();

        // Fixed length 5, pulse every 16 clocks.
        s_len = 5; s_start = 1; tick();
        wr_log.delete(); done_cnt = 0;
        repeat (SF) pulse_gap(16);
        chk("settle_no_write", wr_log.size(), 0);
        repeat (5) pulse_gap(16);
        repeat (4) tick();
        chk("fixed_writes", wr_log.size(), 5);
        for (int i = 0; i < 5 && i < wr_log.size(); i++) chk("fixed_addr", wr_log[i], i);
        chk("fixed_done_cnt", done_cnt, 1);
        chk("fixed_state", int'(state_out), 0);
        chk("fixed_frames", int'(frames_written_out), 5);
        chk("model_pin_total", m_total, 5);

        // start and stop together in IDLE
        s_start = 1; s_stop = 1; tick();
        chk("start_stop_idle", int'(state_out), 0);

        // Continuous ring, a stray start mid-capture, stop on the 13th pulse.
        run_to_capture(0);
        wr_log.delete(); done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 6) begin
                tick(); s_start = 1; tick(); tick(); tick();
            end else begin
                repeat (4) tick();
            end
            s_pulse = 1; s_left = 16'($urandom); s_right = 16'($urandom); tick();
        end
        repeat (4) tick();
        s_pulse = 1; s_stop = 1; tick();
        repeat (3) tick();
        chk("ring_writes", wr_log.size(), 12);
        for (int i = 0; i < 12 && i < wr_log.size(); i++) chk("ring_addr", wr_log[i], i % DEPTH);
        chk("ring_state", int'(state_out), 0);
        chk("ring_done_cnt", done_cnt, 0);

        // Watchdog with no pulses.
        settle_at = -1; fault_at = -1;
        s_len = 3; s_start = 1; tick();
        repeat (110) tick();
        chk("wd_latency", fault_at - settle_at, WD);
        chk("wd_state", int'(state_out), 5);
        chk("wd_error", int'(error_out), 1);
        chk("wd_rx_reset", int'(rx_reset_out), 1);
        s_stop = 1; tick();
        chk("fault_stop_state", int'(state_out), 0);
        chk("fault_stop_error", int'(error_out), 1);
        s_start = 1; tick();
        chk("restart_state", int'(state_out), 1);
        chk("restart_error", int'(error_out), 0);
        repeat (2) tick();
        s_stop = 1; tick();

        // Reset while the write to address 3 is on the bus.
        run_to_capture(0);
        repeat (4) pulse_gap(4);
        chk("pre_reset_addr", int'(buf_addr_out), 3);
        s_rst = 1; tick();
        chk("mid_reset_state", int'(state_out), 0);
        chk("mid_reset_we", int'(buf_we_out), 0);
        chk("mid_reset_rx_reset", int'(rx_reset_out), 1);
        chk("mid_reset_frames", int'(frames_written_out), 0);
        repeat (2) tick();

`ifdef PEAK_DETECT_EN
        run_to_capture(2);
        repeat (3) tick();
        s_pulse = 1; s_left = 16'h8000; s_right = 16'hfffb; tick();
        repeat (3) tick();
        s_pulse = 1; s_left = 16'd100; s_right = 16'd7; tick();
        repeat (3) tick();
        chk("peak_left_lit", int'(peak_left_out), 32767);
        chk("peak_right_lit", int'(peak_right_out), 7);
`endif

        // Random traffic.
        gap = 3;
        for (int i = 0; i < 6000; i++) begin
            s_len = ($urandom_range(0, 3) == 0) ? '0 : (AW + 1)'($urandom_range(1, FW_MAX));
            if (gap == 0) begin
                s_pulse = 1; s_left = 16'($urandom); s_right = 16'($urandom);
                gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 130))
                                                  : int'($urandom_range(0, 12));
            end else begin
                gap--;
            end
            if ($urandom_range(0, 119) == 0) s_start = 1;
            if ($urandom_range(0, 299) == 0) s_stop = 1;
            if ($urandom_range(0, 2499) == 0) s_rst = 1;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mic_capture_sequencer.md
Name: mic_capture_sequencer

Overview:
Controller that sequences the I2S microphone receiver and moves its stereo samples into a sample-buffer BRAM. It holds the receiver in reset while idle, releases it on command and discards a settling period of frames while the mics power up. It then writes {left,right} frames to sequential buffer addresses, with either a fixed frame count or continuous ring capture. A watchdog flags a dead I2S link.

Parameters:
ADDR_WIDTH, 10, buffer address width; buffer depth is 2^ADDR_WIDTH frames
SETTLE_FRAMES, 2048, frames discarded after receiver release (must be >= 1)
RX_RESET_CYCLES, 4, clocks rx_reset_out held high in RESET_RX
WATCHDOG_CYCLES, 4096, max clocks between rx_new_sample_in pulses in SETTLE/CAPTURE

Ports:
clock_in  input  1  100 MHz system clock
reset_in  input  1  synchronous, active-high reset
start_in  input  1  one-cycle start command
stop_in  input  1  one-cycle abort/stop command
capture_len_in  input  ADDR_WIDTH+1  frames to capture; 0 = continuous ring; sampled on accepted start
rx_reset_out  output  1  drives receiver reset_in
rx_left_in  input  16  receiver left sample
rx_right_in  input  16  receiver right sample
rx_new_sample_in  input  1  receiver one-cycle new-sample pulse
buf_we_out  output  1  buffer write enable
buf_addr_out  output  ADDR_WIDTH  buffer write address
buf_data_out  output  32  {left[15:0], right[15:0]}
busy_out  output  1  high in any state except IDLE and FAULT
done_out  output  1  one-cycle pulse when fixed-length capture completes
error_out  output  1  sticky watchdog fault
state_out  output  3  current state encoding
frames_written_out  output  ADDR_WIDTH+1  frames written in current or last capture (saturates at all-ones)

Behaviour:
- States/encoding: IDLE=0, RESET_RX=1, SETTLE=2, CAPTURE=3, DONE=4, FAULT=5.
- Reset values: state IDLE, rx_reset_out=1, buf_we_out=0, buf_addr_out=0, buf_data_out=0, busy_out=0, done_out=0, error_out=0, frames_written_out=0; all counters 0.
- IDLE: rx_reset_out=1. start_in -> RESET_RX. Latch capture_len_in, clear address, frames_written and error_out.
- RESET_RX: rx_reset_out=1 for exactly RX_RESET_CYCLES clocks, then SETTLE.
- SETTLE: rx_reset_out=0. Count rx_new_sample_in pulses. The pulse that makes the count equal SETTLE_FRAMES is discarded, and the state moves to CAPTURE on the next cycle. No buffer writes occur in SETTLE.
- CAPTURE: every rx_new_sample_in pulse causes exactly one write. buf_we_out is high for one cycle, the cycle after the pulse. buf_addr_out is the current address and buf_data_out is {rx_left_in, rx_right_in}, registered on the pulse cycle. The address increments after each write and wraps 2^ADDR_WIDTH-1 -> 0.
- Fixed length (latched len != 0): the write of frame len is the final write. In the next cycle the state is DONE; done_out pulses 1 cycle in DONE, then IDLE. len may exceed depth; the address then wraps.
- Continuous (latched len == 0): runs until stop_in; done_out never pulses.
- stop_in in RESET_RX/SETTLE/CAPTURE/DONE: next state IDLE. If a sample pulse coincides with stop_in, no write occurs. A write already registered from the previous cycle still completes.
- stop_in and start_in together in IDLE: stop wins; state stays IDLE.
- start_in while not IDLE/FAULT: ignored.
- Watchdog: counter clears on each rx_new_sample_in and on entry to SETTLE. It increments in SETTLE/CAPTURE. On reaching WATCHDOG_CYCLES, next state is FAULT and error_out=1.
- FAULT: rx_reset_out=1, no writes. error_out stays high until start_in (restart as from IDLE) or reset_in. stop_in moves FAULT -> IDLE with error_out kept high.
- frames_written_out increments with every buf_we_out; it is retained in IDLE until the next accepted start.
- reset_in mid-operation: all outputs return to reset values on the next edge. Any pending write is dropped.

Optional Feature:
PEAK_DETECT_EN: when defined, adds outputs peak_left_out[15:0] and peak_right_out[15:0]. These hold the maximum absolute value (signed two's complement input) of samples written during the current capture. -32768 saturates to 32767. They update in the same cycle as buf_we_out and clear to 0 on accepted start. When undefined, these ports and their logic are absent and all other behaviour is identical.

Test Plan:
- Pulse every 16 clocks, SETTLE_FRAMES=8, len=5, start -> first 8 pulses produce no write; 5 writes at addr 0..4 each 1 cycle after its pulse; done_out pulses once; state returns 0; frames_written_out=5.
- ADDR_WIDTH=3, len=0, 12 captured pulses then stop_in -> addresses 0..7,0..3; stop coinciding with 13th pulse gives no 13th write; state 0.
- No pulses after start, WATCHDOG_CYCLES=100 -> FAULT 100 clocks after SETTLE entry; error_out=1, rx_reset_out=1; start_in clears error_out and enters RESET_RX.
- start_in with stop_in in IDLE -> stays IDLE; start_in during CAPTURE -> ignored, address sequence unaffected.
- reset_in asserted mid-CAPTURE at addr 3 -> next edge: state 0, buf_we_out=0, rx_reset_out=1, frames_written_out=0.
- PEAK_DETECT_EN: samples left -32768, 100; right -5, 7 -> peak_left_out=32767, peak_right_out=7.
